// File: rtl/krnl_sobel_mul_pkg.sv
// rtl/krnl_sobel_mul_pkg.sv - shared constants and width helper for the sobel multiply pipe
package krnl_sobel_mul_pkg;

    // Legal pipeline depth range for krnl_sobel_mul_pipe.
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 6;

    // Width of the full, untruncated product of an a_w by b_w multiply.
    function automatic int prod_width(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

endpackage

// File: rtl/krnl_sobel_mul_sat.sv
// rtl/krnl_sobel_mul_sat.sv - combinational shift and clamp of the full product to OUT_W
module krnl_sobel_mul_sat
    import krnl_sobel_mul_pkg::*;
#(
    parameter int PW          = 32,
    parameter int OUT_W       = 32,
    parameter int SHIFT       = 0,
    parameter int SIGNED_MODE = 0
) (
    input  logic [PW-1:0]    prod_i,
    output logic [OUT_W-1:0] res_o,
    output logic             sat_o
);

    logic [PW-1:0] shifted;

    // Arithmetic shift keeps the sign of two's-complement products.
    always_comb begin
        if (SIGNED_MODE != 0) begin
            shifted = $unsigned($signed(prod_i) >>> SHIFT);
        end else begin
            shifted = prod_i >> SHIFT;
        end
    end

    generate
        if (OUT_W >= PW) begin : g_fits
            // Result is at least as wide as the product: nothing can overflow.
            if (SIGNED_MODE != 0) begin : g_sext
                assign res_o = OUT_W'($signed(shifted));
            end else begin : g_zext
                assign res_o = OUT_W'(shifted);
            end
            assign sat_o = 1'b0;
        end else if (SIGNED_MODE != 0) begin : g_sclamp
            // In range only when every dropped bit matches the new sign bit.
            logic [PW-OUT_W:0] top_bits;
            logic              ovf;
            assign top_bits = shifted[PW-1:OUT_W-1];
            assign ovf      = ~((&top_bits) | ~(|top_bits));
            assign res_o    = ovf ? (shifted[PW-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                   : {1'b0, {(OUT_W-1){1'b1}}})
                                  : shifted[OUT_W-1:0];
            assign sat_o    = ovf;
        end else begin : g_uclamp
            // Any set bit above OUT_W means the value exceeds the unsigned range.
            logic ovf;
            assign ovf   = |shifted[PW-1:OUT_W];
            assign res_o = ovf ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
            assign sat_o = ovf;
        end
    endgenerate

endmodule

// File: rtl/krnl_sobel_mul_pipe.sv
// rtl/krnl_sobel_mul_pipe.sv - stall-able multiply pipeline; KRNL_SOBEL_MUL_SAT_EN selects clamp instead of wrap
module krnl_sobel_mul_pipe
    import krnl_sobel_mul_pkg::*;
#(
    parameter int A_W         = 16,
    parameter int B_W         = 16,
    parameter int OUT_W       = 32,
    parameter int SHIFT       = 0,
    parameter int STAGES      = 2,
    parameter int SIGNED_MODE = 0,
    parameter int TAG_W       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_p,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_sat
);

    localparam int PW   = prod_width(A_W, B_W);
    localparam int LAST = STAGES - 1;

    logic             valid_q [STAGES];
    logic [TAG_W-1:0] tag_q   [STAGES];
    logic [OUT_W-1:0] out_p_q;
    logic             out_sat_q;

    logic             stall;
    logic             advance;
    logic [PW-1:0]    mul_c;
    logic [PW-1:0]    narrow_in;
    logic [OUT_W-1:0] narrow_p;
    logic             narrow_sat;

    // Whole pipe moves in lockstep; a held output freezes every stage.
    assign out_valid = valid_q[LAST] & ~rst;
    assign stall     = out_valid & ~out_ready;
    assign advance   = ~stall;
    assign in_ready  = ~stall;

    // Operands are widened to the product width first so the multiply is exact.
    generate
        if (SIGNED_MODE != 0) begin : g_smul
            logic signed [PW-1:0] a_ext;
            logic signed [PW-1:0] b_ext;
            assign a_ext = PW'($signed(in_a));
            assign b_ext = PW'($signed(in_b));
            assign mul_c = $unsigned(a_ext * b_ext);
        end else begin : g_umul
            assign mul_c = PW'(in_a) * PW'(in_b);
        end
    endgenerate

    // Stage 1 holds the raw product (DSP output register); later stages retime it.
    generate
        if (STAGES == 1) begin : g_single
            assign narrow_in = mul_c;
        end else begin : g_chain
            logic [PW-1:0] prod_q [STAGES-1];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < STAGES - 1; i++) begin
                        prod_q[i] <= '0;
                    end
                end else if (advance) begin
                    prod_q[0] <= mul_c;
                    for (int i = 1; i < STAGES - 1; i++) begin
                        prod_q[i] <= prod_q[i-1];
                    end
                end
            end
            assign narrow_in = prod_q[STAGES-2];
        end
    endgenerate

`ifdef KRNL_SOBEL_MUL_SAT_EN
    krnl_sobel_mul_sat #(
        .PW          (PW),
        .OUT_W       (OUT_W),
        .SHIFT       (SHIFT),
        .SIGNED_MODE (SIGNED_MODE)
    ) u_sat (
        .prod_i (narrow_in),
        .res_o  (narrow_p),
        .sat_o  (narrow_sat)
    );
`else
    logic [PW-1:0] shifted;

    // Wrap mode: shift, then keep the low OUT_W bits (sign-extending if wider).
    always_comb begin
        if (SIGNED_MODE != 0) begin
            shifted  = $unsigned($signed(narrow_in) >>> SHIFT);
            narrow_p = OUT_W'($signed(shifted));
        end else begin
            shifted  = narrow_in >> SHIFT;
            narrow_p = OUT_W'(shifted);
        end
    end

    assign narrow_sat = 1'b0;
`endif

    // Valid and tag bits travel with the data; bubbles advance like real beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
            end
        end else if (advance) begin
            valid_q[0] <= in_valid;
            tag_q[0]   <= in_tag;
            for (int i = 1; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    // Final stage captures the narrowed result, so narrowing adds no latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_p_q   <= '0;
            out_sat_q <= 1'b0;
        end else if (advance) begin
            out_p_q   <= narrow_p;
            out_sat_q <= narrow_sat;
        end
    end

    assign out_p   = rst ? '0 : out_p_q;
    assign out_tag = rst ? '0 : tag_q[LAST];
    assign out_sat = rst ? 1'b0 : out_sat_q;

endmodule

// File: tb/tb_krnl_sobel_mul_pipe.sv
// tb/tb_krnl_sobel_mul_pipe.sv - directed vector bench for krnl_sobel_mul_pipe
module tb_krnl_sobel_mul_pipe;

`ifdef KRNL_SOBEL_MUL_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // u0: defaults (unsigned 16x16 -> 32, 2 stages)
    logic        iv0 = 0, ir0, ov0, or0 = 1, t0 = 0, ot0, os0;
    logic [15:0] a0 = 0, b0 = 0;
    logic [31:0] p0;
    // u1: signed 8x8 -> 8
    logic        iv1 = 0, ir1, ov1, or1 = 1, t1 = 0, ot1, os1;
    logic [7:0]  a1 = 0, b1 = 0, p1;
    // u2: 4 stages, shift 4
    logic        iv2 = 0, ir2, ov2, or2 = 1, t2 = 0, ot2, os2;
    logic [15:0] a2 = 0, b2 = 0;
    logic [31:0] p2;

    krnl_sobel_mul_pipe u0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_a(a0), .in_b(b0),
        .in_tag(t0), .out_valid(ov0), .out_ready(or0), .out_p(p0), .out_tag(ot0), .out_sat(os0)
    );

    krnl_sobel_mul_pipe #(.A_W(8), .B_W(8), .OUT_W(8), .SIGNED_MODE(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_a(a1), .in_b(b1),
        .in_tag(t1), .out_valid(ov1), .out_ready(or1), .out_p(p1), .out_tag(ot1), .out_sat(os1)
    );

    krnl_sobel_mul_pipe #(.STAGES(4), .SHIFT(4)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_a(a2), .in_b(b2),
        .in_tag(t2), .out_valid(ov2), .out_ready(or2), .out_p(p2), .out_tag(ot2), .out_sat(os2)
    );

    typedef struct {
        int          dut;
        logic [15:0] a;
        logic [15:0] b;
        logic        tag;
        logic [31:0] exp_p;
        logic        exp_sat;
    } vec_t;

    vec_t vecs[15];
    int   tests  = 0;
    int   failed = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic t);
        case (d)
            0: begin iv0 = v; a0 = a; b0 = b; t0 = t; end
            1: begin iv1 = v; a1 = a[7:0]; b1 = b[7:0]; t1 = t; end
            default: begin iv2 = v; a2 = a; b2 = b; t2 = t; end
        endcase
    endtask

    task automatic get(input int d, output logic ov, output logic [31:0] p, output logic t,
                       output logic s);
        case (d)
            0: begin ov = ov0; p = p0; t = ot0; s = os0; end
            1: begin ov = ov1; p = {24'h0, p1}; t = ot1; s = os1; end
            default: begin ov = ov2; p = p2; t = ot2; s = os2; end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ov, t, s, seen;
        logic [31:0] p, prev_p;
        logic        prev_stall;
        logic        pat [4];
        int          lat, tx, rx;

        // u0 unsigned, 2-cycle latency
        vecs[0]  = '{0, 16'd300,   16'd200,   1'b1, 32'd60000,     1'b0};
        vecs[1]  = '{0, 16'd0,     16'd1234,  1'b0, 32'd0,         1'b0};
        vecs[2]  = '{0, 16'hFFFF,  16'hFFFF,  1'b1, 32'hFFFE0001,  1'b0};
        vecs[3]  = '{0, 16'd255,   16'd256,   1'b0, 32'd65280,     1'b0};
        vecs[4]  = '{0, 16'd40000, 16'd3,     1'b1, 32'd120000,    1'b0};
        // u1 signed 8-bit: clamp or wrap depending on build
        vecs[5]  = '{1, 16'h0080,  16'h00FF,  1'b1, SAT ? 32'h7F : 32'h80, SAT};
        vecs[6]  = '{1, 16'h00FD,  16'h0005,  1'b0, 32'hF1,        1'b0};
        vecs[7]  = '{1, 16'h0010,  16'h0010,  1'b1, SAT ? 32'h7F : 32'h00, SAT};
        vecs[8]  = '{1, 16'h00F0,  16'h0010,  1'b0, SAT ? 32'h80 : 32'h00, SAT};
        vecs[9]  = '{1, 16'h0007,  16'h00F7,  1'b1, 32'hC1,        1'b0};
        // u2 unsigned, shift 4, 4-cycle latency
        vecs[10] = '{2, 16'hFFFF,  16'h0010,  1'b1, 32'h0000FFFF,  1'b0};
        vecs[11] = '{2, 16'h1234,  16'h0100,  1'b0, 32'h00012340,  1'b0};
        vecs[12] = '{2, 16'd7,     16'd3,     1'b1, 32'd1,         1'b0};
        vecs[13] = '{2, 16'hFFFF,  16'hFFFF,  1'b0, 32'h0FFFE000,  1'b0};
        vecs[14] = '{0, 16'd1,     16'd1,     1'b0, 32'd1,         1'b0};

        // Reset state
        tick;
        tick;
        check("rst_u0_valid", ov0, 0);
        check("rst_u0_in_ready", ir0, 1);
        check("rst_u0_p", p0, 0);
        check("rst_u2_valid", ov2, 0);
        rst = 1'b0;
        tick;
        check("post_rst_in_ready", ir0, 1);

        // Single beats with latency check
        for (int i = 0; i < 15; i++) begin
            lat = (vecs[i].dut == 2) ? 4 : 2;
            drive(vecs[i].dut, 1'b1, vecs[i].a, vecs[i].b, vecs[i].tag);
            tick;
            drive(vecs[i].dut, 1'b0, 16'h0, 16'h0, 1'b0);
            for (int c = 1; c < lat; c++) begin
                get(vecs[i].dut, ov, p, t, s);
                check($sformatf("v%0d_early_valid", i), ov, 0);
                tick;
            end
            get(vecs[i].dut, ov, p, t, s);
            check($sformatf("v%0d_valid", i), ov, 1);
            check($sformatf("v%0d_p", i), p, vecs[i].exp_p);
            check($sformatf("v%0d_tag", i), t, vecs[i].tag);
            check($sformatf("v%0d_sat", i), s, vecs[i].exp_sat);
            tick;
        end

        // Streaming with out_ready pattern 1,0,0,1
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        tx = 0; rx = 0; prev_stall = 0; prev_p = 0;
        for (int cyc = 0; cyc < 100 && rx < 8; cyc++) begin
            or0 = pat[cyc % 4];
            if (tx < 8) begin
                iv0 = 1; a0 = 16'(tx); b0 = 16'(tx + 1);
            end else begin
                iv0 = 0;
            end
            #1;
            if (prev_stall) begin
                check("stream_hold_valid", ov0, 1);
                check("stream_hold_p", p0, prev_p);
            end
            if (ov0 && or0) begin
                check($sformatf("stream_p%0d", rx), p0, 32'(rx * (rx + 1)));
                rx++;
            end
            prev_stall = ov0 && !or0;
            prev_p     = p0;
            if (iv0 && ir0) tx++;
            tick;
        end
        check("stream_count", 32'(rx), 8);
        iv0 = 0; or0 = 1;
        tick;
        tick;

        // Reset with two beats in flight
        or0 = 0;
        drive(0, 1'b1, 16'd2, 16'd3, 1'b1);
        tick;
        drive(0, 1'b1, 16'd4, 16'd5, 1'b0);
        tick;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        check("stall_valid", ov0, 1);
        check("stall_p", p0, 6);
        check("stall_in_ready", ir0, 0);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", ir0, 1);
        check("midrst_valid", ov0, 0);
        check("midrst_p", p0, 0);
        tick;
        rst = 1'b0;
        #1;
        check("after_rst_valid", ov0, 0);
        check("after_rst_in_ready", ir0, 1);
        or0  = 1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick;
            if (ov0) seen = 1;
        end
        check("flushed_no_valid", seen, 0);
        drive(0, 1'b1, 16'd7, 16'd9, 1'b1);
        tick;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        check("rst_next_early", ov0, 0);
        tick;
        check("rst_next_valid", ov0, 1);
        check("rst_next_p", p0, 63);
        check("rst_next_tag", ot0, 1);
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
